ack_pulse_responder: RTL and testbench

- Receiver-side responder for the transmit/receive acknowledge protocol.
- Each accepted transmit request is answered with exactly ACK_COUNT single-cycle acknowledge pulses, starting one cycle after the request. Pulses are separated by a programmable gap, so they may be non-consecutive.
- Requests that arrive while a response is in progress are queued in a saturating pending counter.
- Sits opposite the transmitter. Its output must satisfy "tx_req |-> ##1 (rx_ack)[=ACK_COUNT]" for every request.

---
 rtl/ack_resp_pkg.sv | 25 ++
 rtl/ack_pend_counter.sv | 53 +++++
 rtl/ack_pulse_responder.sv | 157 +++++++++++++++
 tb/tb_ack_pulse_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ack_resp_pkg.sv
// Shared definitions for the acknowledge-pulse responder.
//   state_e        : responder FSM states
//   *_DEF          : default parameter values
//   resp_len()     : cycles from first to last ack pulse of one response
package ack_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_QUIET = 2'd3
    } state_e;

    localparam int unsigned ACK_COUNT_DEF = 2;
    localparam int unsigned GAP_W_DEF     = 4;
    localparam int unsigned QUIET_DEF     = 1;
    localparam int unsigned PEND_W_DEF    = 3;

    // ack_count high cycles separated by (ack_count-1) gaps of 'gap' low cycles
    function automatic int unsigned resp_len(input int unsigned ack_count,
                                             input int unsigned gap);
        return ack_count + (ack_count - 1) * gap;
    endfunction

endpackage

// File: rtl/ack_pend_counter.sv
// Saturating pending-request counter with a sticky overflow flag.
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : one new request to queue
//   dec       : one queued request taken for service
//   cnt       : number of queued requests
//   overflow  : sticky, set when inc arrives (without dec) at saturation
module ack_pend_counter
    import ack_resp_pkg::*;
#(
    parameter int unsigned W = PEND_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         overflow
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        // inc and dec together cancel: one in, one out
        if (inc && !dec) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt      = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/ack_pulse_responder.sv
// Receiver-side acknowledge responder. Every accepted tx_req is answered
// with ACK_COUNT single-cycle rx_ack pulses starting one cycle later,
// separated by gap_cfg low cycles and followed by QUIET low cycles.
// Requests arriving during a response are queued in a saturating counter.
//   clk, rst  : clock, asynchronous active-high reset
//   tx_req    : transmit request
//   gap_cfg   : low cycles between pulses, latched at response start
//   rx_ack    : registered acknowledge pulse
//   busy      : registered, high whenever the FSM is not idle
//   pend_cnt  : queued, unserviced requests
//   overflow  : sticky, a request was dropped at queue saturation
module ack_pulse_responder
    import ack_resp_pkg::*;
#(
    parameter int unsigned ACK_COUNT = ACK_COUNT_DEF,
    parameter int unsigned GAP_W     = GAP_W_DEF,
    parameter int unsigned QUIET     = QUIET_DEF,
    parameter int unsigned PEND_W    = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_req,
    input  logic [GAP_W-1:0]  gap_cfg,
    output logic              rx_ack,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    localparam int unsigned     PC_W       = $clog2(ACK_COUNT + 1);
    localparam int unsigned     QC_W       = (QUIET > 1) ? $clog2(QUIET + 1) : 1;
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(ACK_COUNT);
    localparam logic [QC_W-1:0] QUIET_LOAD = QC_W'(QUIET);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [GAP_W-1:0]  gap_ctr_q, gap_ctr_d;
    logic [GAP_W-1:0]  gap_lat_q, gap_lat_d;
    logic [QC_W-1:0]   quiet_ctr_q, quiet_ctr_d;
    logic              rx_ack_q, rx_ack_d;
    logic              busy_q, busy_d;

    logic              start;
    logic              req_avail;
    logic              pend_inc;
    logic              pend_dec;
    logic [PEND_W-1:0] pend_val;
    logic              pend_ovf;

    assign req_avail = tx_req || (pend_val != '0);

    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        gap_ctr_d   = gap_ctr_q;
        gap_lat_d   = gap_lat_q;
        quiet_ctr_d = quiet_ctr_q;
        start       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_req) begin
                    start = 1'b1;
                end
            end
            ST_PULSE: begin
                if (pulse_cnt_q < PULSE_LAST) begin
                    if (gap_lat_q == '0) begin
                        state_d     = ST_PULSE;
                        pulse_cnt_d = pulse_cnt_q + PC_W'(1);
                    end else begin
                        state_d   = ST_GAP;
                        gap_ctr_d = gap_lat_q;
                    end
                end else if (QUIET != 0) begin
                    state_d     = ST_QUIET;
                    quiet_ctr_d = QUIET_LOAD;
                end else if (req_avail) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_ctr_d = gap_ctr_q - GAP_W'(1);
                if (gap_ctr_q <= GAP_W'(1)) begin
                    state_d     = ST_PULSE;
                    pulse_cnt_d = pulse_cnt_q + PC_W'(1);
                end
            end
            ST_QUIET: begin
                quiet_ctr_d = quiet_ctr_q - QC_W'(1);
                if (quiet_ctr_q <= QC_W'(1)) begin
                    if (req_avail) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d     = ST_PULSE;
            pulse_cnt_d = PC_W'(1);
            gap_lat_d   = gap_cfg;
        end

        // outputs registered from the next state so they align with it
        rx_ack_d = (state_d == ST_PULSE);
        busy_d   = (state_d != ST_IDLE);
    end

    // A start with an empty queue consumes tx_req directly (IDLE start, or
    // a fresh request at the end of a response). A start with a non-empty
    // queue serves the oldest entry while any coincident tx_req is queued.
    assign pend_dec = start && (pend_val != '0);
    assign pend_inc = tx_req && !(start && (pend_val == '0));

    ack_pend_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .inc      (pend_inc),
        .dec      (pend_dec),
        .cnt      (pend_val),
        .overflow (pend_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pulse_cnt_q <= '0;
            gap_ctr_q   <= '0;
            gap_lat_q   <= '0;
            quiet_ctr_q <= '0;
            rx_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            gap_ctr_q   <= gap_ctr_d;
            gap_lat_q   <= gap_lat_d;
            quiet_ctr_q <= quiet_ctr_d;
            rx_ack_q    <= rx_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_ack   = rx_ack_q;
    assign busy     = busy_q;
    assign pend_cnt = pend_val;
    assign overflow = pend_ovf;

endmodule

// File: tb/tb_ack_pulse_responder.sv
// Directed bench for ack_pulse_responder (ACK_COUNT=2, GAP_W=4, QUIET=1,
// PEND_W=3). Edge numbers in each step count from the first edge of that
// step; "value at edge k" is the register value held into edge k.
module tb_ack_pulse_responder;

    localparam int unsigned ACK_COUNT = 2;
    localparam int unsigned GAP_W     = 4;
    localparam int unsigned QUIET     = 1;
    localparam int unsigned PEND_W    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              tx_req;
    logic [GAP_W-1:0]  gap_cfg;
    logic              rx_ack;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    int owed   = 0;

    logic [255:0]      req_mask;
    logic [255:0]      ack_h, busy_h, ovf_h, exp_v;
    int                pend_h [256];
    logic [GAP_W-1:0]  ga, gb;
    int unsigned       gsw;

    ack_pulse_responder #(
        .ACK_COUNT (ACK_COUNT),
        .GAP_W     (GAP_W),
        .QUIET     (QUIET),
        .PEND_W    (PEND_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_req   (tx_req),
        .gap_cfg  (gap_cfg),
        .rx_ack   (rx_ack),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Protocol monitor: every rx_ack high cycle must be covered by an
    // earlier request still owed pulses (tx_req |-> ##1 rx_ack[=ACK_COUNT]).
    always @(negedge clk) begin
        if (rst) begin
            owed = 0;
        end else begin
            if (rx_ack === 1'b1) begin
                checks++;
                assert (owed > 0) else begin
                    errors++;
                    $error("FAIL proto_owed: rx_ack high with owed=%0d, required owed>0", owed);
                end
                if (owed > 0) owed--;
            end
            if (tx_req === 1'b1) owed += ACK_COUNT;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_step(input logic [GAP_W-1:0] a, input logic [GAP_W-1:0] b,
                              input int unsigned sw);
        req_mask = '0;
        ack_h    = '0;
        busy_h   = '0;
        ovf_h    = '0;
        exp_v    = '0;
        for (int i = 0; i < 256; i++) pend_h[i] = 0;
        ga  = a;
        gb  = b;
        gsw = sw;
    endtask

    // Drive edges 1..n; record outputs as seen going into edge e+1.
    task automatic run(input int unsigned n);
        for (int unsigned e = 1; e <= n; e++) begin
            tx_req  = req_mask[e];
            gap_cfg = (e >= gsw) ? gb : ga;
            @(posedge clk);
            #1;
            ack_h[e+1]  = rx_ack;
            busy_h[e+1] = busy;
            ovf_h[e+1]  = overflow;
            pend_h[e+1] = int'(pend_cnt);
        end
        tx_req = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        tx_req  = 1'b0;
        gap_cfg = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 256'({rx_ack, busy, pend_cnt, overflow}), 256'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single request, gap 1
        clear_step(4'd1, 4'd1, 999);
        req_mask[2] = 1'b1;
        run(10);
        exp_v[3] = 1'b1; exp_v[5] = 1'b1;
        chk("single_ack", ack_h, exp_v);
        exp_v = '0;
        for (int i = 3; i <= 6; i++) exp_v[i] = 1'b1;
        chk("single_busy", busy_h, exp_v);
        chk("single_busy_len", 256'($countones(busy_h)),
            256'(ack_resp_pkg::resp_len(ACK_COUNT, 1) + QUIET));
        chk("single_pend", 256'(pend_h[3]), 256'd0);

        // gap 0: back-to-back pulses then QUIET
        clear_step(4'd0, 4'd0, 999);
        req_mask[2] = 1'b1;
        run(8);
        exp_v[3] = 1'b1; exp_v[4] = 1'b1;
        chk("gap0_ack", ack_h, exp_v);
        chk("gap0_quiet", 256'({ack_h[5], busy_h[5], busy_h[6]}), 256'(3'b010));

        // two requests, gap 2
        clear_step(4'd2, 4'd2, 999);
        req_mask[2] = 1'b1; req_mask[4] = 1'b1;
        run(14);
        exp_v[3] = 1'b1; exp_v[6] = 1'b1; exp_v[8] = 1'b1; exp_v[11] = 1'b1;
        chk("two_ack", ack_h, exp_v);
        chk("two_pend_after4", 256'(pend_h[5]), 256'd1);
        chk("two_pend_after6", 256'(pend_h[7]), 256'd1);
        chk("two_pend_after7", 256'(pend_h[8]), 256'd0);
        chk("two_busy_end", 256'({busy_h[12], busy_h[13]}), 256'(2'b10));

        // gap 0, request coincident with a queue start keeps pend_cnt
        clear_step(4'd0, 4'd0, 999);
        req_mask[2] = 1'b1; req_mask[3] = 1'b1; req_mask[5] = 1'b1;
        run(14);
        exp_v[3] = 1'b1; exp_v[4] = 1'b1; exp_v[6] = 1'b1;
        exp_v[7] = 1'b1; exp_v[9] = 1'b1; exp_v[10] = 1'b1;
        chk("coinc_ack", ack_h, exp_v);
        chk("coinc_pend", 256'({pend_h[4][3:0], pend_h[6][3:0], pend_h[9][3:0]}),
            256'(12'h110));

        // fresh request at QUIET end with empty queue is consumed directly
        clear_step(4'd0, 4'd0, 999);
        req_mask[2] = 1'b1; req_mask[5] = 1'b1;
        run(10);
        exp_v[3] = 1'b1; exp_v[4] = 1'b1; exp_v[6] = 1'b1; exp_v[7] = 1'b1;
        chk("direct_ack", ack_h, exp_v);
        chk("direct_pend", 256'(pend_h[6]), 256'd0);

        // gap_cfg changed after the first pulse has no effect
        clear_step(4'd3, 4'd0, 4);
        req_mask[2] = 1'b1;
        run(12);
        exp_v[3] = 1'b1; exp_v[7] = 1'b1;
        chk("gapchg_ack", ack_h, exp_v);

        // saturation, gap 15, tx_req held for edges 2..11
        clear_step(4'd15, 4'd15, 999);
        for (int i = 2; i <= 11; i++) req_mask[i] = 1'b1;
        run(150);
        for (int i = 0; i < 8; i++) begin
            exp_v[3 + 18*i]  = 1'b1;
            exp_v[19 + 18*i] = 1'b1;
        end
        chk("sat_ack", ack_h, exp_v);
        chk("sat_ack_count", 256'($countones(ack_h)), 256'd16);
        chk("sat_pend_9_10_12", 256'({pend_h[9][3:0], pend_h[10][3:0], pend_h[12][3:0]}),
            256'(12'h677));
        chk("sat_ovf_edge", 256'({ovf_h[10], ovf_h[11]}), 256'(2'b01));
        chk("sat_pend_dec", 256'(pend_h[21]), 256'd6);
        chk("sat_end", 256'({ovf_h[151], busy_h[151], pend_h[151][2:0]}), 256'(5'b10000));

        // reset mid-response with two queued requests (overflow still set)
        clear_step(4'd4, 4'd4, 999);
        req_mask[2] = 1'b1; req_mask[3] = 1'b1; req_mask[4] = 1'b1;
        run(4);
        chk("prerst_state", 256'({busy, pend_cnt, overflow}), 256'({1'b1, 3'd2, 1'b1}));
        rst = 1'b1;
        #1;
        chk("async_reset", 256'({rx_ack, busy, pend_cnt, overflow}), 256'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_step(4'd4, 4'd4, 999);
        run(30);
        chk("postrst_no_ack", ack_h | busy_h, 256'd0);

        // new request after reset is served normally
        clear_step(4'd1, 4'd1, 999);
        req_mask[2] = 1'b1;
        run(8);
        exp_v[3] = 1'b1; exp_v[5] = 1'b1;
        chk("postrst_ack", ack_h, exp_v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
